// File: rtl/snake_game_scheduler_if.sv
// Handshake bundle between the snake game scheduler and the game datapath.
// Latency: none, wires only.
// Backpressure: none; every strobe is a single-cycle pulse that is never held off.
//
// Signals
//   start     master->slave  begin a new game (honoured in IDLE/OVER)
//   pause     master->slave  one-cycle pulse, toggles RUN<->PAUSE
//   collide   master->slave  game logic reports death (honoured in RUN)
//   move_tick slave->master  one-cycle strobe, advance snake one cell
//   sec_tick  slave->master  one-cycle strobe, one RUN second elapsed
//   bcd       slave->master  elapsed seconds {d3,d2,d1,d0}, BCD
//   level     slave->master  current speed level
//   state     slave->master  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
interface snake_game_scheduler_if;
  logic        start;
  logic        pause;
  logic        collide;
  logic        move_tick;
  logic        sec_tick;
  logic [15:0] bcd;
  logic [2:0]  level;
  logic [1:0]  state;

  // Game logic side: drives controls, consumes strobes and status.
  modport master (
    output start, pause, collide,
    input  move_tick, sec_tick, bcd, level, state
  );

  // Scheduler side.
  modport slave (
    input  start, pause, collide,
    output move_tick, sec_tick, bcd, level, state
  );
endinterface

// File: rtl/snake_game_scheduler.sv
// Game-phase controller: IDLE/RUN/PAUSE/OVER sequencing, move/second strobes, BCD timer, speed level.
// Latency: strobes are registered, high in the cycle after a RUN terminal count; state changes one edge after the input.
// Backpressure: none; pause freezes every counter so the remaining period is preserved across the pause.
//
// Ports
//   CLOCK_50  in   system clock
//   resetn    in   synchronous active-low reset, overrides everything
//   io_bus    slave modport of snake_game_scheduler_if (start/pause/collide in,
//             move_tick/sec_tick/bcd/level/state out)
module snake_game_scheduler #(
  parameter int unsigned SEC_CYCLES = 50_000_000,
  parameter int unsigned MOVE_SLOW  = 6_000_000,
  parameter int unsigned MOVE_STEP  = 1_000_000,
  parameter int unsigned MOVE_MIN   = 2_000_000,
  parameter int unsigned LEVEL_SECS = 10,
  parameter int unsigned MAX_LEVEL  = 7
) (
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  snake_game_scheduler_if.slave  io_bus
);

  // Counter widths sized to the largest value each counter can hold.
  localparam int unsigned MOVE_MAX = (MOVE_SLOW > MOVE_MIN) ? MOVE_SLOW : MOVE_MIN;
  localparam int MW = $clog2(MOVE_MAX) + 1;
  localparam int SW = $clog2(SEC_CYCLES) + 1;
  localparam int LW = $clog2(LEVEL_SECS + 1) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  state_t      r_state;
  logic [MW-1:0] r_move_cnt;
  logic [SW-1:0] r_sec_cnt;
  logic [LW-1:0] r_lvl_sec;
  logic [2:0]  r_level;
  logic [15:0] r_bcd;
  logic        r_move_tick;
  logic        r_sec_tick;

  logic [31:0]   w_dec;
  logic [MW-1:0] w_period;
  logic          w_move_tc;
  logic          w_sec_tc;
  logic          w_lvl_wrap;

  // Four-digit BCD increment with full ripple; 9999 wraps to 0000.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Move period from the current level. The floor test is done before the
  // subtraction (in 33 bits) so a large level*step never wraps the period.
  always_comb begin
    w_dec = 32'(r_level) * 32'(MOVE_STEP);
    if (({1'b0, w_dec} + 33'(MOVE_MIN)) >= 33'(MOVE_SLOW)) begin
      w_period = MW'(MOVE_MIN);
    end else begin
      w_period = MW'(32'(MOVE_SLOW) - w_dec);
    end
  end

  // >= rather than == so a period that shrinks below the running count
  // still produces a tick on the next cycle instead of running away.
  assign w_move_tc  = (r_move_cnt >= (w_period - MW'(1)));
  assign w_sec_tc   = (r_sec_cnt >= SW'(SEC_CYCLES - 1));
  assign w_lvl_wrap = ((r_lvl_sec + LW'(1)) >= LW'(LEVEL_SECS));

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_move_cnt  <= '0;
      r_sec_cnt   <= '0;
      r_lvl_sec   <= '0;
      r_level     <= '0;
      r_bcd       <= '0;
      r_move_tick <= 1'b0;
      r_sec_tick  <= 1'b0;
    end else begin
      // Strobes default low; only a RUN terminal count raises them.
      r_move_tick <= 1'b0;
      r_sec_tick  <= 1'b0;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (io_bus.start) begin
            r_state    <= ST_RUN;
            r_move_cnt <= '0;
            r_sec_cnt  <= '0;
            r_lvl_sec  <= '0;
            r_level    <= '0;
            r_bcd      <= '0;
          end
        end
        ST_RUN: begin
          // A leaving cycle does not count: any terminal count is dropped
          // and the counters keep their values for a later resume.
          if (io_bus.collide) begin
            r_state <= ST_OVER;
          end else if (io_bus.pause) begin
            r_state <= ST_PAUSE;
          end else begin
            if (w_move_tc) begin
              r_move_cnt  <= '0;
              r_move_tick <= 1'b1;
            end else begin
              r_move_cnt <= r_move_cnt + MW'(1);
            end
            if (w_sec_tc) begin
              r_sec_cnt  <= '0;
              r_sec_tick <= 1'b1;
              r_bcd      <= bcd_inc(r_bcd);
              if (w_lvl_wrap) begin
                r_lvl_sec <= '0;
                if (r_level < 3'(MAX_LEVEL)) begin
                  r_level <= r_level + 3'd1;
                end
              end else begin
                r_lvl_sec <= r_lvl_sec + LW'(1);
              end
            end else begin
              r_sec_cnt <= r_sec_cnt + SW'(1);
            end
          end
        end
        ST_PAUSE: begin
          if (io_bus.pause) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.move_tick = r_move_tick;
  assign io_bus.sec_tick  = r_sec_tick;
  assign io_bus.bcd       = r_bcd;
  assign io_bus.level     = r_level;
  assign io_bus.state     = r_state;

endmodule

// File: tb/tb_snake_game_scheduler.sv
// Directed bench for snake_game_scheduler: phase sequencing, tick timing, level ramp,
// pause/resume, collide priority, mid-game reset, and BCD ripple on a fast-second instance.
module tb_snake_game_scheduler;

  logic clk;
  logic resetn;

  snake_game_scheduler_if gif ();
  snake_game_scheduler_if gif2 ();

  snake_game_scheduler #(
    .SEC_CYCLES(20), .MOVE_SLOW(8), .MOVE_STEP(2), .MOVE_MIN(4),
    .LEVEL_SECS(2), .MAX_LEVEL(3)
  ) u_dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .io_bus   (gif)
  );

  snake_game_scheduler #(
    .SEC_CYCLES(2), .MOVE_SLOW(8), .MOVE_STEP(2), .MOVE_MIN(4),
    .LEVEL_SECS(2), .MAX_LEVEL(3)
  ) u_dut_fast (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .io_bus   (gif2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  int mq[$];
  int sq[$];
  int exp_mv[$];
  int ticks;

  initial begin
    resetn = 1'b0;
    gif.start = 1'b0; gif.pause = 1'b0; gif.collide = 1'b0;
    gif2.start = 1'b0; gif2.pause = 1'b0; gif2.collide = 1'b0;
    repeat (3) step();
    resetn = 1'b1;

    // Reset state
    chk("rst_state", 32'(gif.state), 32'h0);
    chk("rst_bcd",   32'(gif.bcd),   32'h0);
    chk("rst_level", 32'(gif.level), 32'h0);
    chk("rst_ticks", 32'({gif.move_tick, gif.sec_tick}), 32'h0);

    // pause is ignored in IDLE
    gif.pause = 1'b1; step(); gif.pause = 1'b0; step();
    chk("idle_pause", 32'(gif.state), 32'h0);

    // Game A: tick schedule and level ramp. A start pulse mid-game must be ignored.
    gif.start = 1'b1; step(); gif.start = 1'b0;
    chk("a_state_e", 32'(gif.state), 32'h1);
    for (int k = 0; k <= 175; k++) begin
      if (gif.move_tick) mq.push_back(k);
      if (gif.sec_tick)  sq.push_back(k);
      case (k)
        39:  chk("lvl_e39",  32'(gif.level), 32'd0);
        40:  chk("lvl_e40",  32'(gif.level), 32'd1);
        79:  chk("lvl_e79",  32'(gif.level), 32'd1);
        80:  chk("lvl_e80",  32'(gif.level), 32'd2);
        119: chk("lvl_e119", 32'(gif.level), 32'd2);
        120: chk("lvl_e120", 32'(gif.level), 32'd3);
        175: begin
          chk("lvl_e175", 32'(gif.level), 32'd3);
          chk("bcd_e175", 32'(gif.bcd),   32'h0008);
        end
        default: ;
      endcase
      gif.start = (k == 50);
      step();
    end
    gif.start = 1'b0;

    // P=8 until level 1 at E+40, P=6 until level 2 at E+80 (count already 4, so
    // tick at E+81), then P=4 (level 3 floors at 4 as well).
    exp_mv = '{8, 16, 24, 32, 40, 46, 52, 58, 64, 70, 76};
    for (int t = 81; t <= 173; t += 4) exp_mv.push_back(t);
    chk("mv_count", 32'(mq.size()), 32'(exp_mv.size()));
    for (int i = 0; i < exp_mv.size(); i++)
      chk($sformatf("mv_at_%0d", i), (i < mq.size()) ? 32'(mq[i]) : 32'hffffffff, 32'(exp_mv[i]));
    chk("sec_count", 32'(sq.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("sec_at_%0d", i), (i < sq.size()) ? 32'(sq[i]) : 32'hffffffff, 32'(20 * (i + 1)));

    // End game A by collision; final values held.
    gif.collide = 1'b1; step(); gif.collide = 1'b0;
    chk("a_over_state", 32'(gif.state), 32'h3);
    chk("a_over_level", 32'(gif.level), 32'd3);
    chk("a_over_bcd",   32'(gif.bcd),   32'h0008);

    // Game B: start from OVER clears level/bcd; pause at move_cnt=5.
    gif.start = 1'b1; step(); gif.start = 1'b0;
    chk("b_state_e", 32'(gif.state), 32'h1);
    chk("b_bcd_e",   32'(gif.bcd),   32'h0);
    chk("b_level_e", 32'(gif.level), 32'h0);
    repeat (5) step();
    gif.pause = 1'b1; step(); gif.pause = 1'b0;
    chk("b_paused", 32'(gif.state), 32'h2);
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      if (gif.move_tick || gif.sec_tick) ticks++;
      gif.collide = (i == 50);
      gif.start   = (i == 60);
      step();
    end
    gif.collide = 1'b0; gif.start = 1'b0;
    chk("pause_state", 32'(gif.state), 32'h2);
    chk("pause_ticks", 32'(ticks), 32'd0);
    gif.pause = 1'b1; step(); gif.pause = 1'b0;
    chk("resume_state", 32'(gif.state), 32'h1);
    chk("resume_r0", 32'(gif.move_tick), 32'h0);
    step(); chk("resume_r1", 32'(gif.move_tick), 32'h0);
    step(); chk("resume_r2", 32'(gif.move_tick), 32'h0);
    step(); chk("resume_r3", 32'(gif.move_tick), 32'h1);
    // sec count resumed from 5, so its tick lands at R+15.
    repeat (12) step();
    chk("b_sec_r15", 32'(gif.sec_tick), 32'h1);
    chk("b_bcd_r15", 32'(gif.bcd), 32'h0001);

    // collide+pause on a move terminal count (R+18): OVER, tick dropped.
    repeat (3) step();
    gif.collide = 1'b1; gif.pause = 1'b1; step(); gif.collide = 1'b0; gif.pause = 1'b0;
    chk("cp_state", 32'(gif.state), 32'h3);
    chk("cp_mtick", 32'(gif.move_tick), 32'h0);
    chk("cp_bcd",   32'(gif.bcd), 32'h0001);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      if (gif.move_tick || gif.sec_tick) ticks++;
      gif.pause = (i == 3);
      step();
    end
    gif.pause = 1'b0;
    chk("over_hold_state", 32'(gif.state), 32'h3);
    chk("over_hold_ticks", 32'(ticks), 32'd0);
    chk("over_hold_bcd",   32'(gif.bcd), 32'h0001);

    // Game C: restart, then reset mid-RUN on a move terminal count (E+23).
    gif.start = 1'b1; step(); gif.start = 1'b0;
    chk("c_state_e", 32'(gif.state), 32'h1);
    chk("c_bcd_e",   32'(gif.bcd),   32'h0);
    repeat (23) step();
    chk("c_bcd_e23", 32'(gif.bcd), 32'h0001);
    resetn = 1'b0; step(); resetn = 1'b1;
    chk("mrst_state", 32'(gif.state), 32'h0);
    chk("mrst_bcd",   32'(gif.bcd),   32'h0);
    chk("mrst_level", 32'(gif.level), 32'h0);
    chk("mrst_ticks", 32'({gif.move_tick, gif.sec_tick}), 32'h0);
    repeat (5) step();
    chk("mrst_idle", 32'(gif.state), 32'h0);

    // Fast-second instance: bcd equals k seconds at cycle E+2k.
    gif2.start = 1'b1; step(); gif2.start = 1'b0;
    for (int k = 0; k <= 20000; k++) begin
      case (k)
        18:    chk("bcd_0009", 32'(gif2.bcd), 32'h0009);
        20:    chk("bcd_0010", 32'(gif2.bcd), 32'h0010);
        198:   chk("bcd_0099", 32'(gif2.bcd), 32'h0099);
        200:   chk("bcd_0100", 32'(gif2.bcd), 32'h0100);
        1998:  chk("bcd_0999", 32'(gif2.bcd), 32'h0999);
        2000:  chk("bcd_1000", 32'(gif2.bcd), 32'h1000);
        19998: chk("bcd_9999", 32'(gif2.bcd), 32'h9999);
        20000: chk("bcd_wrap", 32'(gif2.bcd), 32'h0000);
        default: ;
      endcase
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
